// File: rtl/sound_sequencer_pkg.sv
// Shared definitions for the sound sequencer: state encoding, sound-event
// bit positions, default timing values and the fixed-priority pick helper.
package sound_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } seq_state_t;

    localparam int EV_WALL   = 0;
    localparam int EV_PADDLE = 1;
    localparam int EV_BRICK  = 2;
    localparam int EV_LIFE   = 3;

    localparam int unsigned DEF_MS_DIV  = 50000;
    localparam int unsigned DEF_NOTE_MS = 100;
    localparam int unsigned DEF_GAP_MS  = 20;

    localparam logic [31:0] DEF_DIV0 = 32'hBAA;
    localparam logic [31:0] DEF_DIV1 = 32'hA64;
    localparam logic [31:0] DEF_DIV2 = 32'h941;
    localparam logic [31:0] DEF_DIV3 = 32'h7C9;

    // Life lost outranks brick, paddle and wall hits.
    function automatic logic [1:0] highest_pending(input logic [3:0] p);
        if (p[EV_LIFE])        return 2'(EV_LIFE);
        else if (p[EV_BRICK])  return 2'(EV_BRICK);
        else if (p[EV_PADDLE]) return 2'(EV_PADDLE);
        else                   return 2'(EV_WALL);
    endfunction

endpackage

// File: rtl/sound_sequencer_ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every MS_DIV clocks, restartable
// with a synchronous clear so each phase starts on a fresh millisecond.
module ms_tick_gen
    import sound_sequencer_pkg::*;
#(
    parameter int unsigned MS_DIV = DEF_MS_DIV
) (
    input  logic clk50mhz,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    logic [31:0] cnt;

    assign tick = (cnt == MS_DIV - 1);

    // NOTE: sequential state is always written with non-blocking assignments
    // so every register samples values from before the clock edge.
    always_ff @(posedge clk50mhz) begin
        if (reset || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/sound_sequencer.sv
// Game sound sequencer: latches sound events, plays one note at a time with a
// silent gap, and steps the external sine-ROM address using count enables.
module sound_sequencer
    import sound_sequencer_pkg::*;
#(
    parameter int unsigned MS_DIV  = DEF_MS_DIV,
    parameter int unsigned NOTE_MS = DEF_NOTE_MS,
    parameter int unsigned GAP_MS  = DEF_GAP_MS,
    parameter logic [31:0] DIV0    = DEF_DIV0,
    parameter logic [31:0] DIV1    = DEF_DIV1,
    parameter logic [31:0] DIV2    = DEF_DIV2,
    parameter logic [31:0] DIV3    = DEF_DIV3
) (
    input  logic       clk50mhz,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [4:0] rom_addr,
    output logic       audio_en,
    output logic [1:0] note_id,
    output logic       busy
);

    seq_state_t  state, state_next;
    logic [3:0]  pending;
    logic [3:0]  grant_mask;
    logic [1:0]  grant_idx;
    logic        grant;
    logic        state_change;
    logic        ms_tick;
    logic        step;
    logic [31:0] div_cnt;
    logic [31:0] ms_cnt;
    logic [31:0] div_sel;

    assign audio_en     = (state == ST_PLAY);
    assign busy         = (state != ST_IDLE);
    assign state_change = (state_next != state);

    ms_tick_gen #(
        .MS_DIV(MS_DIV)
    ) u_ms_tick_gen (
        .clk50mhz(clk50mhz),
        .reset   (reset),
        .clear   (state_change || !busy),
        .tick    (ms_tick)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_idx  = highest_pending(pending);
        grant_mask = 4'b0000;
        case (state)
            ST_IDLE: begin
                if (pending != 4'b0000) begin
                    grant      = 1'b1;
                    grant_mask = 4'b0001 << grant_idx;
                    state_next = ST_PLAY;
                end
            end
            ST_PLAY: if (ms_tick && ms_cnt == NOTE_MS - 1) state_next = ST_GAP;
            ST_GAP:  if (ms_tick && ms_cnt == GAP_MS - 1)  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        case (note_id)
            2'd0:    div_sel = DIV0;
            2'd1:    div_sel = DIV1;
            2'd2:    div_sel = DIV2;
            default: div_sel = DIV3;
        endcase
    end

    // A divisor of 0 or 1 advances the ROM address on every cycle.
    assign step = (div_sel <= 32'd1) || (div_cnt == div_sel - 32'd1);

    always_ff @(posedge clk50mhz) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk50mhz) begin
        if (reset) begin
            pending  <= '0;
            note_id  <= '0;
            rom_addr <= '0;
            div_cnt  <= '0;
            ms_cnt   <= '0;
        end else begin
            // The grant clear wins over a same-cycle request for that event.
            pending <= (pending | req) & ~grant_mask;
            if (grant) begin
                note_id  <= grant_idx;
                rom_addr <= '0;
                div_cnt  <= '0;
                ms_cnt   <= '0;
            end else if (state_change) begin
                rom_addr <= '0;
                div_cnt  <= '0;
                ms_cnt   <= '0;
            end else begin
                if (ms_tick && busy) begin
                    ms_cnt <= ms_cnt + 32'd1;
                end
                if (state == ST_PLAY) begin
                    if (step) begin
                        div_cnt  <= '0;
                        rom_addr <= rom_addr + 5'd1;
                    end else begin
                        div_cnt  <= div_cnt + 32'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer: note timing, priority, merging,
// no-preemption, ROM address wrap and reset abort.
module tb_sound_sequencer;
    import sound_sequencer_pkg::*;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] req_w;
    logic [4:0] rom_addr,  rom_addr_w;
    logic       audio_en,  audio_en_w;
    logic [1:0] note_id,   note_id_w;
    logic       busy,      busy_w;

    int checks   = 0;
    int failures = 0;

    sound_sequencer #(
        .MS_DIV(10), .NOTE_MS(3), .GAP_MS(1),
        .DIV0(32'd4), .DIV1(32'd5), .DIV2(32'd6), .DIV3(32'd7)
    ) dut (
        .clk50mhz(clk), .reset(reset), .req(req),
        .rom_addr(rom_addr), .audio_en(audio_en), .note_id(note_id), .busy(busy)
    );

    sound_sequencer #(
        .MS_DIV(10), .NOTE_MS(4), .GAP_MS(1),
        .DIV0(32'd1), .DIV1(32'd5), .DIV2(32'd6), .DIV3(32'd7)
    ) dut_w (
        .clk50mhz(clk), .reset(reset), .req(req_w),
        .rom_addr(rom_addr_w), .audio_en(audio_en_w), .note_id(note_id_w), .busy(busy_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({audio_en, busy, note_id, rom_addr});
    endfunction

    // Starts at PLAY cycle 0 and checks 30 PLAY plus 10 GAP cycles, driving
    // inj_val on req during every cycle whose inj_mask bit is set.
    task automatic play_note(input logic [1:0] note, input int div,
                             input logic [39:0] inj_mask, input logic [3:0] inj_val);
        for (int c = 0; c < 40; c++) begin
            logic [9:0] exp;
            if (c < 30) exp = {1'b1, 1'b1, note, 5'(c / div)};
            else        exp = {1'b0, 1'b1, note, 5'd0};
            check($sformatf("note%0d_c%0d", note, c), outs(), 32'(exp));
            req = inj_mask[c] ? inj_val : 4'd0;
            cycle();
        end
        req = 4'd0;
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'd0;
        req_w = 4'd0;
        cycle();
        cycle();
        check("reset_outs",    outs(), 32'd0);
        check("reset_pending", 32'(dut.pending), 32'd0);
        reset = 1'b0;
        cycle();
        check("idle_after_reset", outs(), 32'd0);

        // ROM address wrap with DIV0=1 over a 40-cycle note.
        req_w = 4'b0001;
        cycle();
        req_w = 4'd0;
        check("wrap_pending_idle", 32'({busy_w, dut_w.pending}), 32'h01);
        cycle();
        for (int c = 0; c < 40; c++) begin
            check($sformatf("wrap_c%0d", c), 32'({audio_en_w, rom_addr_w}), 32'({1'b1, 5'(c % 32)}));
            cycle();
        end
        check("wrap_gap", 32'({audio_en_w, busy_w, rom_addr_w}), 32'({1'b0, 1'b1, 5'd0}));

        // Single wall-hit pulse.
        req = 4'b0001;
        cycle();
        req = 4'd0;
        check("single_pending", 32'({busy, dut.pending}), 32'h01);
        cycle();
        play_note(2'd0, 4, 40'd0, 4'd0);
        check("single_idle", outs(), 32'({1'b0, 1'b0, 2'd0, 5'd0}));

        // Brick and wall together: brick first, wall after gap plus one idle.
        req = 4'b0101;
        cycle();
        req = 4'd0;
        cycle();
        play_note(2'd2, 6, 40'd0, 4'd0);
        check("prio_idle_between", outs(), 32'({1'b0, 1'b0, 2'd2, 5'd0}));
        check("prio_pending_left", 32'(dut.pending), 32'h1);
        cycle();
        play_note(2'd0, 4, 40'd0, 4'd0);
        check("prio_idle_end", outs(), 32'({1'b0, 1'b0, 2'd0, 5'd0}));

        // Life-lost mid-PLAY of a paddle note must not preempt it.
        req = 4'b0010;
        cycle();
        req = 4'd0;
        cycle();
        play_note(2'd1, 5, 40'd1 << 15, 4'b1000);
        check("nopreempt_idle", outs(), 32'({1'b0, 1'b0, 2'd1, 5'd0}));
        check("nopreempt_pending", 32'(dut.pending), 32'h8);
        cycle();
        play_note(2'd3, 7, 40'd0, 4'd0);
        check("nopreempt_idle_end", outs(), 32'({1'b0, 1'b0, 2'd3, 5'd0}));

        // Wall request repeated in its own grant cycle, paddle pulsed three
        // times while busy: one wall note, then exactly one paddle note.
        req = 4'b0001;
        cycle();
        cycle();
        req = 4'd0;
        play_note(2'd0, 4, (40'd1 << 2) | (40'd1 << 17) | (40'd1 << 35), 4'b0010);
        check("merge_pending", 32'(dut.pending), 32'h2);
        cycle();
        play_note(2'd1, 5, 40'd0, 4'd0);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("merge_quiet_%0d", c), outs(), 32'({1'b0, 1'b0, 2'd1, 5'd0}));
            cycle();
        end

        // Reset 12 cycles into a life-lost note with another life-lost pending.
        req = 4'b1000;
        cycle();
        req = 4'd0;
        cycle();
        for (int c = 0; c < 12; c++) begin
            req = (c == 2) ? 4'b1000 : 4'd0;
            cycle();
        end
        req = 4'd0;
        check("abort_before", outs(), 32'({1'b1, 1'b1, 2'd3, 5'd1}));
        check("abort_pending_before", 32'(dut.pending), 32'h8);
        reset = 1'b1;
        req   = 4'b1000;
        cycle();
        check("abort_outs",    outs(), 32'd0);
        check("abort_pending", 32'(dut.pending), 32'd0);
        check("abort_state",   32'(dut.state), 32'(ST_IDLE));
        reset = 1'b0;
        req   = 4'd0;
        for (int c = 0; c < 30; c++) begin
            cycle();
            check($sformatf("abort_quiet_%0d", c), outs(), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
